// File: rtl/push_arbiter_rr.sv
// Merges NUM_CH push-only producers into one push stream. Each channel has its own
// small queue; grants are round-robin or fixed priority and respect downstream_full.
module push_arbiter_rr #(
    parameter int WIDTH     = 240,
    parameter int NUM_CH    = 2,
    parameter int LOG_DEPTH = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] wrdata_in,
    input  logic [NUM_CH-1:0]       push_in,
    output logic [NUM_CH-1:0]       full_out,
    output logic [NUM_CH-1:0]       overflow,
    output logic [WIDTH-1:0]        wrdata_out,
    output logic                    push_out,
    output logic [2:0]              grant_id,
    input  logic                    downstream_full
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem_r      [NUM_CH][DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_r   [NUM_CH];
    logic [LOG_DEPTH-1:0] rd_ptr_r   [NUM_CH];
    logic [LOG_DEPTH:0]   count_r    [NUM_CH];
    logic [LOG_DEPTH:0]   count_nx_s [NUM_CH];
    logic [2:0]           rr_ptr_r;
    logic [NUM_CH-1:0]    push_ok_s;
    logic [NUM_CH-1:0]    pop_s;
    logic [7:0]           nonempty_s;
    logic                 grant_s;
    logic [2:0]           win_s;
    logic [2:0]           cand_s;
    logic [WIDTH-1:0]     rd_data_s;

    // (base + offset) mod NUM_CH, offset never exceeds NUM_CH-1
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end else begin
            sum = sum;
        end
        return 3'(sum);
    endfunction

    // Per-channel accept, pop and next-count decode
    always_comb begin
        nonempty_s = 8'd0;
        push_ok_s  = '0;
        pop_s      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty_s[c] = (count_r[c] != '0);
            push_ok_s[c]  = push_in[c] & ~full_out[c];
            pop_s[c]      = grant_s & (win_s == 3'(c));
            count_nx_s[c] = count_r[c] + (LOG_DEPTH + 1)'(push_ok_s[c])
                                       - (LOG_DEPTH + 1)'(pop_s[c]);
        end
    end

    // Winner select: iterate from the lowest-preference slot so the preferred one is written last
    always_comb begin
        grant_s = 1'b0;
        win_s   = 3'd0;
        cand_s  = 3'd0;
        if (!downstream_full) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                cand_s = (PRIO_MODE == 1) ? 3'(i) : rr_index(rr_ptr_r, i);
                if (nonempty_s[cand_s]) begin
                    grant_s = 1'b1;
                    win_s   = cand_s;
                end else begin
                    grant_s = grant_s;
                    win_s   = win_s;
                end
            end
        end else begin
            grant_s = 1'b0;
            win_s   = 3'd0;
        end
    end

    // Head-of-queue mux for the winning channel
    always_comb begin
        rd_data_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (win_s == 3'(c)) begin
                rd_data_s = mem_r[c][rd_ptr_r[c]];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Queue storage, payload only, so it carries no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_ok_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= wrdata_in[c*WIDTH +: WIDTH];
            end
        end
    end

    // Queue pointers, occupancy, full and sticky overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_r[c] <= '0;
                rd_ptr_r[c] <= '0;
                count_r[c]  <= '0;
            end
            full_out <= '0;
            overflow <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_ok_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + LOG_DEPTH'(1);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + LOG_DEPTH'(1);
                end
                count_r[c]  <= count_nx_s[c];
                full_out[c] <= (count_nx_s[c] == DEPTH_CNT);
                // A push into a full queue is lost even if that queue pops this cycle
                if (push_in[c] && full_out[c]) begin
                    overflow[c] <= 1'b1;
                end
            end
        end
    end

    // Registered merged output; rr_ptr_r holds the next slot to search from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_out   <= 1'b0;
            wrdata_out <= '0;
            grant_id   <= 3'd0;
            rr_ptr_r   <= 3'd0;
        end else if (grant_s) begin
            push_out   <= 1'b1;
            wrdata_out <= rd_data_s;
            grant_id   <= win_s;
            rr_ptr_r   <= rr_index(win_s, 1);
        end else begin
            push_out   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_push_arbiter_rr.sv
// Directed bench for push_arbiter_rr: a round-robin instance with a per-channel
// scoreboard, and a fixed-priority instance for grant ordering.
module tb_push_arbiter_rr;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4*W-1:0] wrdata_in = '0;
    logic [3:0]    push_in = 4'b0;
    logic [3:0]    full_out, overflow;
    logic [W-1:0]  wrdata_out;
    logic          push_out;
    logic [2:0]    grant_id;
    logic          downstream_full = 1'b0;

    logic [4*W-1:0] p_wrdata_in = '0;
    logic [3:0]    p_push_in = 4'b0;
    logic [3:0]    p_full_out, p_overflow;
    logic [W-1:0]  p_wrdata_out;
    logic          p_push_out;
    logic [2:0]    p_grant_id;
    logic          p_downstream_full = 1'b0;

    int checks = 0;
    int errors = 0;
    int pop_total = 0;
    logic ds_at_edge = 1'b0;
    logic [W-1:0] exp_q [4][$];
    logic [2:0]   obs_gid [$];
    logic [2:0]   p_obs_gid [$];
    logic [W-1:0] p_obs_data [$];
    logic [W-1:0] p_exp_data [$];

    push_arbiter_rr #(.WIDTH(W), .NUM_CH(4), .LOG_DEPTH(2), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .wrdata_in(wrdata_in), .push_in(push_in),
        .full_out(full_out), .overflow(overflow), .wrdata_out(wrdata_out),
        .push_out(push_out), .grant_id(grant_id), .downstream_full(downstream_full)
    );

    push_arbiter_rr #(.WIDTH(W), .NUM_CH(4), .LOG_DEPTH(2), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .wrdata_in(p_wrdata_in), .push_in(p_push_in),
        .full_out(p_full_out), .overflow(p_overflow), .wrdata_out(p_wrdata_out),
        .push_out(p_push_out), .grant_id(p_grant_id), .downstream_full(p_downstream_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of downstream_full the DUT saw at the last edge
    always @(posedge clk) ds_at_edge <= downstream_full;

    // Scoreboard consumer: every merged push pops the head of its channel's queue
    always @(negedge clk) begin
        if (rst_n && push_out) begin
            obs_gid.push_back(grant_id);
            pop_total++;
            check("bp_hold", {63'd0, ds_at_edge}, 64'd0);
            if (grant_id > 3'd3) begin
                check("gid_range", {61'd0, grant_id}, 64'd3);
            end else begin
                check("sb_nonempty", {63'd0, exp_q[grant_id].size() != 0}, 64'd1);
                if (exp_q[grant_id].size() != 0)
                    check("sb_data", {48'd0, wrdata_out}, {48'd0, exp_q[grant_id].pop_front()});
            end
        end
        if (rst_n && p_push_out) begin
            p_obs_gid.push_back(p_grant_id);
            p_obs_data.push_back(p_wrdata_out);
        end
    end

    task automatic step(input logic [3:0] mask, input logic ds, input logic accept);
        logic [W-1:0] d;
        downstream_full = ds;
        push_in = mask;
        for (int c = 0; c < 4; c++) begin
            d = W'($urandom);
            wrdata_in[c*W +: W] = d;
            if (mask[c] && accept) exp_q[c].push_back(d);
        end
        @(posedge clk); #1;
        push_in = 4'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        obs_gid.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        // Reset state
        #3;
        check("rst_push_out", {63'd0, push_out}, 64'd0);
        check("rst_full", {60'd0, full_out}, 64'd0);
        check("rst_overflow", {60'd0, overflow}, 64'd0);
        check("rst_wrdata", {48'd0, wrdata_out}, 64'd0);
        check("rst_gid", {61'd0, grant_id}, 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Latency: push in cycle k, merged push in cycle k+2
        push_in = 4'b0010;
        wrdata_in[1*W +: W] = 16'h00A5;
        exp_q[1].push_back(16'h00A5);
        @(posedge clk); #1;
        push_in = 4'b0000;
        check("lat_k1_idle", {63'd0, push_out}, 64'd0);
        @(posedge clk); #1;
        check("lat_k2_push", {63'd0, push_out}, 64'd1);
        check("lat_k2_data", {48'd0, wrdata_out}, 64'h00A5);
        check("lat_k2_gid", {61'd0, grant_id}, 64'd1);
        cyc(3);

        // Overflow: four entries fill the queue, the fifth is dropped
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("ovf_not_full_at3", {63'd0, full_out[0]}, 64'd0);
            step(4'b0001, 1'b1, 1'b1);
        end
        check("ovf_full_at4", {63'd0, full_out[0]}, 64'd1);
        check("ovf_clear_at4", {63'd0, overflow[0]}, 64'd0);
        step(4'b0001, 1'b1, 1'b0);
        check("ovf_set", {63'd0, overflow[0]}, 64'd1);
        check("ovf_full_hold", {63'd0, full_out[0]}, 64'd1);
        pop_total = 0;
        downstream_full = 1'b0;
        cyc(8);
        check("ovf_pops", pop_total, 64'd4);
        check("ovf_sticky", {63'd0, overflow[0]}, 64'd1);
        check("ovf_full_drop", {63'd0, full_out[0]}, 64'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        check("pre_rst_full1", {63'd0, full_out[1]}, 64'd1);
        downstream_full = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_push", {63'd0, push_out}, 64'd1);
        #2;
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        #1;
        check("arst_push_out", {63'd0, push_out}, 64'd0);
        check("arst_full", {60'd0, full_out}, 64'd0);
        check("arst_overflow", {60'd0, overflow}, 64'd0);
        check("arst_wrdata", {48'd0, wrdata_out}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // Round-robin fairness: four full channels drained in strict rotation
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b1);
        check("rr_all_full", {60'd0, full_out}, 64'hF);
        obs_gid.delete();
        downstream_full = 1'b0;
        cyc(20);
        check("rr_count", obs_gid.size(), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < obs_gid.size()) check("rr_seq", {61'd0, obs_gid[i]}, i % 4);
        end
        for (int c = 0; c < 4; c++) check("rr_drained", exp_q[c].size(), 64'd0);

        // Backpressure toggling every cycle during a 20-entry stream
        do_reset();
        pop_total = 0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] m;
            int sel;
            sel = (i / 2) % 3;
            m = (i % 2 == 0) ? ((sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0010 : 4'b1000) : 4'b0000;
            step(m, (i % 2 == 1), 1'b1);
        end
        downstream_full = 1'b0;
        cyc(10);
        check("bp_delivered", pop_total, 64'd20);
        for (int c = 0; c < 4; c++) check("bp_drained", exp_q[c].size(), 64'd0);
        check("bp_no_ovf", {60'd0, overflow}, 64'd0);

        // Fixed priority: ch0 drains completely before ch2
        do_reset();
        p_downstream_full = 1'b1;
        p_exp_data.delete();
        for (int i = 0; i < 3; i++) begin
            d = W'($urandom);
            p_wrdata_in[0*W +: W] = d;
            p_exp_data.push_back(d);
            p_wrdata_in[2*W +: W] = W'($urandom);
            p_push_in = 4'b0101;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            p_exp_data.push_back(p_wrdata_in[2*W +: W]);
        end
        p_push_in = 4'b0000;
        p_obs_gid.delete();
        p_obs_data.delete();
        p_downstream_full = 1'b0;
        cyc(10);
        check("prio_count", p_obs_gid.size(), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < p_obs_gid.size()) begin
                check("prio_gid", {61'd0, p_obs_gid[i]}, (i < 3) ? 64'd0 : 64'd2);
                if (i < 3) check("prio_data_ch0", {48'd0, p_obs_data[i]}, {48'd0, p_exp_data[i]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
